// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM states, default sizing and
// the fixed requester slots used by the game logic.
package adder_arbiter_pkg;

  localparam int WIDTH_DEF   = 10;  // VGA coordinate range
  localparam int N_REQ_DEF   = 4;
  localparam int ID_W_DEF    = 2;
  localparam int ADD_LAT_DEF = 1;

  // Requester slots as wired in the top level
  localparam int REQ_PLAYER = 0;
  localparam int REQ_ROCK   = 1;
  localparam int REQ_SCORE  = 2;
  localparam int REQ_SCROLL = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// when searching ptr, ptr+1, ... wrapping modulo N_REQ.
module rr_pick
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  win_id
);

  // Walk from the farthest candidate to the nearest so the nearest set bit wins
  always_comb begin
    // NOTE: every output gets a default first so no path through the loop
    // leaves it unassigned, which would otherwise infer a latch.
    any    = 1'b0;
    win_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        any    = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Time-multiplexes one shared adder among N_REQ requesters. Round-robin pick
// in IDLE, one-cycle grant in ISSUE, ADD_LAT cycles of WAIT, result captured
// on leaving DONE and strobed on rsp_valid for one cycle.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]   req_sub,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_sub,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_cout
);

  // Counter only needs to reach ADD_LAT-1; keep at least one bit for ADD_LAT<=1
  localparam int              CNT_W     = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((ADD_LAT > 0) ? ADD_LAT - 1 : 0);

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_id;
  logic [CNT_W-1:0]  wait_cnt;

  logic              pick_any;
  logic [ID_W-1:0]   pick_id;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic              sel_sub;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .win_id (pick_id)
  );

  // Route the candidate winner's operands toward the operand registers
  always_comb begin
    sel_a   = req_a[int'(pick_id)*WIDTH +: WIDTH];
    sel_b   = req_b[int'(pick_id)*WIDTH +: WIDTH];
    sel_sub = req_sub[pick_id];
  end

  assign busy = (state != ST_IDLE);

  // Arbitration FSM with registered grant, operand and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win_id    <= '0;
      wait_cnt  <= '0;
      gnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_sub   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; pulse outputs default low and are set only when due.
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            add_a   <= sel_a;
            add_b   <= sel_b;
            add_sub <= sel_sub;
            win_id  <= pick_id;
            gnt     <= N_REQ'(1) << pick_id;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= (ADD_LAT == 0) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= ST_DONE;
          else                       wait_cnt <= wait_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          rsp_data  <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= win_id;
          rsp_valid <= 1'b1;
          ptr       <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed literal cases, reset during
// an operation, round-robin order, then randomized traffic compared every
// cycle against a transaction-level countdown model.
module tb_adder_arbiter;

  localparam int W    = 10;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 1;
  localparam int MODV = 1 << W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     req_sub = '0;
  logic [N-1:0]     gnt;
  logic             busy;
  logic [W-1:0]     add_a, add_b;
  logic             add_sub;
  logic [W-1:0]     add_sum;
  logic             add_cout;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_data;
  logic             rsp_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(IDW), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .gnt(gnt), .busy(busy), .add_a(add_a), .add_b(add_b),
    .add_sub(add_sub), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_cout(rsp_cout)
  );

  // Adder model: carry out on add, borrow out on subtract, LAT cycles deep
  logic [W:0] full;
  assign full = add_sub ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
  generate
    if (LAT == 0) begin : g_comb
      assign add_sum  = full[W-1:0];
      assign add_cout = full[W];
    end else begin : g_pipe
      logic [W:0] pipe [LAT];
      always_ff @(posedge clk) begin
        pipe[0] <= full;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign add_sum  = pipe[LAT-1][W-1:0];
      assign add_cout = pipe[LAT-1][W];
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_left = 0;   // busy cycles still to come for the op in flight
  int         m_ptr  = 0;
  int         p_id, p_data, p_cout;
  logic [N-1:0] e_gnt = '0;
  bit         e_rsp_valid = 0;
  int         e_rsp_id = 0, e_rsp_data = 0, e_rsp_cout = 0;
  int         e_a = 0, e_b = 0, e_sub = 0;

  task automatic model_step();
    bit was_idle;
    int w;
    int a, b;
    if (!rst_n) begin
      m_left = 0; m_ptr = 0; e_gnt = '0; e_rsp_valid = 0;
      e_rsp_id = 0; e_rsp_data = 0; e_rsp_cout = 0;
      e_a = 0; e_b = 0; e_sub = 0;
      return;
    end
    was_idle    = (m_left == 0);
    e_gnt       = '0;
    e_rsp_valid = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        e_rsp_valid = 1;
        e_rsp_id    = p_id;
        e_rsp_data  = p_data;
        e_rsp_cout  = p_cout;
        m_ptr       = (p_id + 1) % N;
      end
    end
    if (was_idle && req != 0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      a = int'(req_a[w*W +: W]);
      b = int'(req_b[w*W +: W]);
      e_a = a; e_b = b; e_sub = int'(req_sub[w]);
      if (req_sub[w]) begin
        p_data = (a - b + MODV) % MODV;
        p_cout = (a < b) ? 1 : 0;
      end else begin
        p_data = (a + b) % MODV;
        p_cout = (a + b >= MODV) ? 1 : 0;
      end
      p_id   = w;
      e_gnt  = N'(1) << w;
      m_left = 2 + LAT;
    end
  endtask

  // Single compare process: model advances on each edge, outputs checked 1ns later
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("gnt", gnt, e_gnt);
      check("busy", busy, (m_left > 0));
      check("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid || !rst_n) begin
        check("rsp_id", rsp_id, e_rsp_id);
        check("rsp_data", rsp_data, e_rsp_data);
        check("rsp_cout", rsp_cout, e_rsp_cout);
      end
      if (m_left > 0 || !rst_n) begin
        check("add_a", add_a, e_a);
        check("add_b", add_b, e_b);
        check("add_sub", add_sub, e_sub);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input int id, input int a, input int b, input bit sub);
    req_a[id*W +: W] = W'(a);
    req_b[id*W +: W] = W'(b);
    req_sub[id]      = sub;
    req[id]          = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Issue one op and pin its timing and result against hand-computed literals
  task automatic run_op(input int id, input int a, input int b, input bit sub,
                        input int exp_data, input int exp_cout, input string tag);
    int gc = -1, rc = -1;
    int d = -1, c = -1, rid = -1;
    @(posedge clk); #2;
    set_op(id, a, b, sub);
    for (int k = 1; k <= 20 && rc < 0; k++) begin
      @(posedge clk); #1;
      if (gnt[id] && gc < 0) gc = k;
      if (rsp_valid) begin
        rc = k; d = int'(rsp_data); c = int'(rsp_cout); rid = int'(rsp_id);
      end
      #1;
      if (gc == k) req[id] = 1'b0;
    end
    check({tag, "_gnt_cycle"}, gc, 1);
    check({tag, "_rsp_cycle"}, rc, 3 + LAT);
    check({tag, "_rsp_id"}, rid, id);
    check({tag, "_rsp_data"}, d, exp_data);
    check({tag, "_rsp_cout"}, c, exp_cout);
  endtask

  int order [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int n;
    int gc;
    int seen;
    logic [N-1:0] rearm;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset_busy", busy, 0);
    check("reset_rsp_data", rsp_data, 0);

    // Directed literal cases
    run_op(0, 300, 25, 1'b0, 325, 0, "add");
    run_op(2, 5, 10, 1'b1, 1019, 1, "sub_borrow");
    run_op(3, 1000, 100, 1'b0, 76, 1, "overflow");

    // Reset while the op for requester 1 sits in WAIT
    @(posedge clk); #2;
    set_op(1, 111, 222, 1'b0);
    gc = -1;
    for (int k = 1; k <= 10 && gc < 0; k++) begin
      @(posedge clk); #2;
      if (gnt[1]) gc = k;
    end
    check("rstwait_gnt_cycle", gc, 1);
    req[1] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstwait_busy", busy, 0);
    check("rstwait_add_a", add_a, 0);
    check("rstwait_add_b", add_b, 0);
    check("rstwait_rsp_data", rsp_data, 0);
    check("rstwait_rsp_cout", rsp_cout, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("rstwait_no_rsp", seen, 0);

    // Round-robin with all four held and re-raised after each grant
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1), 1'($urandom));
    n = 0;
    rearm = '0;
    for (int k = 0; k < 60 && n < 5; k++) begin
      @(posedge clk); #1;
      if (gnt != 0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) order[n] = i;
        n++;
      end
      #1;
      for (int i = 0; i < N; i++) if (rearm[i]) req[i] = 1'b1;
      rearm = gnt;
      req   = req & ~gnt;
    end
    check("rr_count", n, 5);
    for (int j = 0; j < 5; j++) check($sformatf("rr_order%0d", j), order[j], exp_order[j]);

    // Randomized traffic; every cycle is checked by the compare process
    req = '0;
    repeat (10) @(posedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (!req[i] && ($urandom % 4 == 0)) begin
          case ($urandom % 4)
            0:       set_op(i, MODV - 1, $urandom_range(0, MODV - 1), 1'($urandom));
            1:       set_op(i, 0, $urandom_range(0, MODV - 1), 1'($urandom));
            default: set_op(i, $urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1), 1'($urandom));
          endcase
        end
      end
      if (cyc == 1500) begin
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk); #2 rst_n = 1'b1;
      end
    end
    req = '0;
    repeat (12) @(posedge clk);
    #3;
    check("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
